// File: rtl/rt_pkg.sv
// Shared ray-tracer types: default coordinate/index widths, the vec3 payload
// and the triangle-issue FSM encoding.
package rt_pkg;

    localparam int unsigned D_BITS = 32;
    localparam int unsigned Q_BITS = 10;
    localparam int unsigned M_BITS = 12;

    typedef struct packed {
        logic signed [D_BITS-1:0] x;
        logic signed [D_BITS-1:0] y;
        logic signed [D_BITS-1:0] z;
    } vec3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAY_RD   = 3'd1,
        TRI_REQ  = 3'd2,
        TRI_WAIT = 3'd3,
        EMIT     = 3'd4
    } issue_state_e;

endpackage

// File: rtl/triangle_issue_if.sv
// Ray FIFO, triangle memory and intersect FIFO signals seen by triangle_issue.
// master is the issue block, slave is the surrounding environment.
interface triangle_issue_if #(
    parameter int unsigned M_BITS = rt_pkg::M_BITS
);
    import rt_pkg::*;

    logic [M_BITS-1:0] num_tri;

    logic              ray_empty;
    logic              ray_rd_en;
    vec3               ray_origin;
    vec3               ray_dir;

    logic [M_BITS-1:0] tri_addr;
    logic              tri_rd_en;
    vec3               tri_v0;
    vec3               tri_v1;
    vec3               tri_v2;

    logic              out_full;
    logic              out_wr_en;
    vec3               out_origin;
    vec3               out_dir;
    vec3               out_v0;
    vec3               out_v1;
    vec3               out_v2;
    logic [M_BITS-1:0] out_triangle_ID;

    logic              busy;

    modport master (
        input  num_tri, ray_empty, ray_origin, ray_dir,
        input  tri_v0, tri_v1, tri_v2, out_full,
        output ray_rd_en, tri_addr, tri_rd_en,
        output out_wr_en, out_origin, out_dir, out_v0, out_v1, out_v2,
        output out_triangle_ID, busy
    );

    modport slave (
        output num_tri, ray_empty, ray_origin, ray_dir,
        output tri_v0, tri_v1, tri_v2, out_full,
        input  ray_rd_en, tri_addr, tri_rd_en,
        input  out_wr_en, out_origin, out_dir, out_v0, out_v1, out_v2,
        input  out_triangle_ID, busy
    );

endinterface

// File: rtl/triangle_issue.sv
// Pairs each incoming ray with every triangle of the scene, in index order,
// and pushes the ray/triangle pairs to the intersect FIFO.
module triangle_issue
    import rt_pkg::*;
#(
    parameter int unsigned Q_BITS = rt_pkg::Q_BITS,
    parameter int unsigned D_BITS = rt_pkg::D_BITS,
    parameter int unsigned M_BITS = rt_pkg::M_BITS
) (
    input  logic             clock,
    input  logic             reset,
    triangle_issue_if.master bus
);

    // Coordinates travel as the shared vec3 type, so widths must agree with it.
    if (D_BITS != rt_pkg::D_BITS) begin : g_bad_d_bits
        $error("triangle_issue: D_BITS must match rt_pkg::D_BITS");
    end
    if (Q_BITS >= D_BITS) begin : g_bad_q_bits
        $error("triangle_issue: Q_BITS must be smaller than D_BITS");
    end

    issue_state_e      state;
    issue_state_e      state_nx;
    logic [M_BITS-1:0] index;
    logic [M_BITS-1:0] index_nx;
    logic [M_BITS-1:0] count;
    vec3               ray_org_q;
    vec3               ray_dir_q;
    logic              last_c;

    // Terminal test uses the count latched with the ray, never the live input.
    assign last_c = (index == count - M_BITS'(1));

    // Write only in EMIT with room downstream; reset kills a pending write.
    assign bus.out_wr_en = (state == EMIT) && !bus.out_full && !reset;

    // Next-state and next-index logic.
    always_comb begin
        state_nx = state;
        index_nx = index;
        case (state)
            IDLE: begin
                if (!bus.ray_empty) begin
                    state_nx = RAY_RD;
                end
            end
            RAY_RD: begin
                index_nx = '0;
                state_nx = (bus.num_tri == '0) ? IDLE : TRI_REQ;
            end
            TRI_REQ: begin
                state_nx = TRI_WAIT;
            end
            TRI_WAIT: begin
                state_nx = EMIT;
            end
            EMIT: begin
                if (!bus.out_full) begin
                    if (last_c) begin
                        state_nx = IDLE;
                    end else begin
                        index_nx = index + M_BITS'(1);
                        state_nx = TRI_REQ;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, strobes and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            index               <= '0;
            count               <= '0;
            ray_org_q           <= '0;
            ray_dir_q           <= '0;
            bus.ray_rd_en       <= 1'b0;
            bus.tri_rd_en       <= 1'b0;
            bus.tri_addr        <= '0;
            bus.busy            <= 1'b0;
            bus.out_origin      <= '0;
            bus.out_dir         <= '0;
            bus.out_v0          <= '0;
            bus.out_v1          <= '0;
            bus.out_v2          <= '0;
            bus.out_triangle_ID <= '0;
        end else begin
            state         <= state_nx;
            index         <= index_nx;
            bus.ray_rd_en <= (state_nx == RAY_RD);
            bus.tri_rd_en <= (state_nx == TRI_REQ);
            bus.busy      <= (state_nx != IDLE);

            if (state_nx == TRI_REQ) begin
                bus.tri_addr <= index_nx;
            end

            // FWFT head is still presented during the pop cycle.
            if (state == RAY_RD) begin
                ray_org_q <= bus.ray_origin;
                ray_dir_q <= bus.ray_dir;
                count     <= bus.num_tri;
            end

            // All pair fields change together on entry to EMIT and then hold.
            if (state == TRI_WAIT) begin
                bus.out_origin      <= ray_org_q;
                bus.out_dir         <= ray_dir_q;
                bus.out_v0          <= bus.tri_v0;
                bus.out_v1          <= bus.tri_v1;
                bus.out_v2          <= bus.tri_v2;
                bus.out_triangle_ID <= index;
            end
        end
    end

endmodule

// File: tb/tb_triangle_issue.sv
// Directed bench for triangle_issue with a FWFT ray FIFO model and a
// one-cycle-latency triangle memory model.
module tb_triangle_issue;
    import rt_pkg::*;

    localparam int unsigned MB = rt_pkg::M_BITS;

    typedef struct packed {
        vec3 org;
        vec3 dir;
    } ray_t;

    logic clock = 1'b0;
    logic reset;

    triangle_issue_if #(.M_BITS(MB)) bus ();

    triangle_issue #(
        .Q_BITS(Q_BITS),
        .D_BITS(D_BITS),
        .M_BITS(MB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rd_n   = 0;
    int busy_fall = -1;
    logic busy_prev = 1'b0;

    ray_t          ray_q[$];
    int            wr_cyc[$];
    logic [MB-1:0] wr_id[$];
    vec3           wr_org[$];
    vec3           wr_dir[$];
    vec3           wr_v0[$];
    vec3           wr_v1[$];
    vec3           wr_v2[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec3 mk(input int x, input int y, input int z);
        vec3 v;
        v.x = 32'(x);
        v.y = 32'(y);
        v.z = 32'(z);
        return v;
    endfunction

    // Triangle k, vertex j: coordinates k*16 offset per vertex and axis.
    function automatic vec3 vert(input int k, input int j);
        return mk(16 * k + 4 * j, 16 * k + 4 * j + 1, 16 * k + 4 * j + 2);
    endfunction

    // Environment: samples strobes and writes on the falling edge, applies
    // FIFO pops and memory reads just after the rising edge.
    initial begin : env_proc
        logic          rd;
        logic          trd;
        logic [MB-1:0] addr;
        bus.ray_empty  = 1'b1;
        bus.ray_origin = '0;
        bus.ray_dir    = '0;
        bus.tri_v0     = '0;
        bus.tri_v1     = '0;
        bus.tri_v2     = '0;
        forever begin
            @(negedge clock);
            rd   = bus.ray_rd_en;
            trd  = bus.tri_rd_en;
            addr = bus.tri_addr;
            if (bus.out_wr_en) begin
                check("wr_while_full", 128'(bus.out_full), 128'(0));
                check("busy_on_wr", 128'(bus.busy), 128'(1));
                wr_cyc.push_back(cyc);
                wr_id.push_back(bus.out_triangle_ID);
                wr_org.push_back(bus.out_origin);
                wr_dir.push_back(bus.out_dir);
                wr_v0.push_back(bus.out_v0);
                wr_v1.push_back(bus.out_v1);
                wr_v2.push_back(bus.out_v2);
            end
            if (rd) begin
                rd_n++;
                check("rd_overlap", 128'(trd), 128'(0));
            end
            if (busy_prev && !bus.busy) busy_fall = cyc;
            busy_prev = bus.busy;
            @(posedge clock);
            cyc++;
            #1;
            if (rd && !reset && ray_q.size() != 0) ray_q.delete(0);
            if (ray_q.size() == 0) begin
                bus.ray_empty  = 1'b1;
                bus.ray_origin = '0;
                bus.ray_dir    = '0;
            end else begin
                bus.ray_empty  = 1'b0;
                bus.ray_origin = ray_q[0].org;
                bus.ray_dir    = ray_q[0].dir;
            end
            if (trd) begin
                bus.tri_v0 = vert(int'(addr), 0);
                bus.tri_v1 = vert(int'(addr), 1);
                bus.tri_v2 = vert(int'(addr), 2);
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic clear_log();
        wr_cyc.delete();
        wr_id.delete();
        wr_org.delete();
        wr_dir.delete();
        wr_v0.delete();
        wr_v1.delete();
        wr_v2.delete();
        rd_n = 0;
        busy_fall = -1;
    endtask

    task automatic push_ray(input vec3 org, input vec3 dir);
        ray_t r;
        r.org = org;
        r.dir = dir;
        ray_q.push_back(r);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        step();
        while (!(ray_q.size() == 0 && !bus.busy) && n < budget) begin
            step();
            n++;
        end
        check("done_in_budget", 128'(n < budget), 128'(1));
    endtask

    task automatic wait_writes(input int k, input int budget);
        int n = 0;
        while (wr_cyc.size() < k && n < budget) begin
            step();
            n++;
        end
        check("writes_in_budget", 128'(wr_cyc.size() >= k), 128'(1));
    endtask

    initial begin : main_proc
        logic any_act;
        int   exp_id[4];
        vec3  exp_org[4];
        reset        = 1'b1;
        bus.num_tri  = '0;
        bus.out_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state and an idle, empty ray FIFO.
        step();
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_ray_rd", 128'(bus.ray_rd_en), 128'(0));
        check("rst_tri_rd", 128'(bus.tri_rd_en), 128'(0));
        check("rst_out_wr", 128'(bus.out_wr_en), 128'(0));
        check("rst_tri_addr", 128'(bus.tri_addr), 128'(0));
        check("rst_out_id", 128'(bus.out_triangle_ID), 128'(0));
        check("rst_out_origin", 128'(bus.out_origin), 128'(0));
        check("rst_out_v2", 128'(bus.out_v2), 128'(0));
        any_act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            any_act = any_act | bus.ray_rd_en | bus.tri_rd_en | bus.out_wr_en | bus.busy;
        end
        check("idle_activity", 128'(any_act), 128'(0));
        check("idle_out_dir", 128'(bus.out_dir), 128'(0));

        // One ray against four triangles.
        clear_log();
        bus.num_tri = MB'(4);
        push_ray(mk(1, 2, 3), mk(0, 0, -1));
        wait_done(100);
        check("r1_count", 128'(wr_cyc.size()), 128'(4));
        for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
            check("r1_id", 128'(wr_id[i]), 128'(i));
            check("r1_v0", 128'(wr_v0[i]), 128'(vert(i, 0)));
            check("r1_v1", 128'(wr_v1[i]), 128'(vert(i, 1)));
            check("r1_v2", 128'(wr_v2[i]), 128'(vert(i, 2)));
            check("r1_origin", 128'(wr_org[i]), 128'(mk(1, 2, 3)));
            check("r1_dir", 128'(wr_dir[i]), 128'(96'h00000000_00000000_FFFFFFFF));
            if (i > 0) check("r1_gap", 128'(wr_cyc[i] - wr_cyc[i-1]), 128'(3));
        end
        if (wr_cyc.size() == 4) check("r1_busy_fall", 128'(busy_fall), 128'(wr_cyc[3] + 1));
        check("r1_busy_end", 128'(bus.busy), 128'(0));

        // Backpressure while ID 1 sits in EMIT.
        clear_log();
        bus.num_tri = MB'(3);
        push_ray(mk(7, -8, 9), mk(1, 0, 0));
        wait_writes(1, 50);
        @(posedge clock);
        #1;
        bus.out_full = 1'b1;
        repeat (8) @(posedge clock);
        step();
        check("stall_no_write", 128'(wr_cyc.size()), 128'(1));
        check("stall_wr_low", 128'(bus.out_wr_en), 128'(0));
        check("stall_id_held", 128'(bus.out_triangle_ID), 128'(1));
        check("stall_v0_held", 128'(bus.out_v0), 128'(vert(1, 0)));
        repeat (4) @(posedge clock);
        #1;
        bus.out_full = 1'b0;
        wait_done(100);
        check("bp_count", 128'(wr_cyc.size()), 128'(3));
        for (int i = 0; i < 3 && i < wr_cyc.size(); i++) begin
            check("bp_id", 128'(wr_id[i]), 128'(i));
            check("bp_v2", 128'(wr_v2[i]), 128'(vert(i, 2)));
        end
        if (wr_cyc.size() == 3) begin
            check("bp_gap_stall", 128'(wr_cyc[1] - wr_cyc[0]), 128'(13));
            check("bp_gap_after", 128'(wr_cyc[2] - wr_cyc[1]), 128'(3));
        end

        // Zero-triangle scene: rays are consumed, nothing is written.
        clear_log();
        bus.num_tri = '0;
        push_ray(mk(1, 1, 1), mk(2, 2, 2));
        push_ray(mk(3, 3, 3), mk(4, 4, 4));
        wait_done(50);
        check("zero_rd_pulses", 128'(rd_n), 128'(2));
        check("zero_writes", 128'(wr_cyc.size()), 128'(0));

        // Back-to-back rays; num_tri raised mid-ray must not extend the first ray.
        clear_log();
        bus.num_tri = MB'(2);
        push_ray(mk(-5, 6, -7), mk(0, 1, 0));
        push_ray(mk(100, -200, 300), mk(1, 1, 1));
        wait_writes(1, 50);
        @(posedge clock);
        #1;
        bus.num_tri = MB'(5);
        repeat (3) @(posedge clock);
        #1;
        bus.num_tri = MB'(2);
        wait_done(100);
        exp_id  = '{0, 1, 0, 1};
        exp_org = '{mk(-5, 6, -7), mk(-5, 6, -7), mk(100, -200, 300), mk(100, -200, 300)};
        check("b2b_count", 128'(wr_cyc.size()), 128'(4));
        for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
            check("b2b_id", 128'(wr_id[i]), 128'(exp_id[i]));
            check("b2b_origin", 128'(wr_org[i]), 128'(exp_org[i]));
        end
        if (wr_cyc.size() == 4) begin
            check("b2b_dir2", 128'(wr_dir[3]), 128'(mk(1, 1, 1)));
            check("b2b_ray_gap", 128'(wr_cyc[2] - wr_cyc[1]), 128'(5));
        end

        // Reset mid-ray after ID 2 of six.
        clear_log();
        bus.num_tri = MB'(6);
        push_ray(mk(11, 12, 13), mk(0, -1, 0));
        wait_writes(3, 60);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step();
        check("mid_rst_busy", 128'(bus.busy), 128'(0));
        check("mid_rst_id", 128'(bus.out_triangle_ID), 128'(0));
        check("mid_rst_v0", 128'(bus.out_v0), 128'(0));
        check("mid_rst_tri_rd", 128'(bus.tri_rd_en), 128'(0));
        repeat (15) step();
        check("mid_rst_writes", 128'(wr_cyc.size()), 128'(3));
        clear_log();
        bus.num_tri = MB'(2);
        push_ray(mk(21, 22, 23), mk(0, 0, 1));
        wait_done(60);
        check("post_rst_count", 128'(wr_cyc.size()), 128'(2));
        for (int i = 0; i < 2 && i < wr_cyc.size(); i++) begin
            check("post_rst_id", 128'(wr_id[i]), 128'(i));
            check("post_rst_v1", 128'(wr_v1[i]), 128'(vert(i, 1)));
            check("post_rst_origin", 128'(wr_org[i]), 128'(mk(21, 22, 23)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/triangle_issue.md
TRIANGLE_ISSUE -- requirements
Module: triangle_issue

Interface
REQ-001 Parameter Q_BITS, default 10, fractional bits of the fixed-point coordinate format (carried, not used arithmetically).
REQ-002 Parameter D_BITS, default 32, coordinate width.
REQ-003 Parameter M_BITS, default 12, triangle index width.
REQ-004 clock  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 num_tri  in  M_BITS  triangle count in scene; sampled when a ray is accepted.
REQ-007 ray_empty  in  1  ray FIFO empty.
REQ-008 ray_rd_en  out  1  ray FIFO read strobe.
REQ-009 ray_origin  in  3 x signed D_BITS  ray origin, first-word-fall-through.
REQ-010 ray_dir  in  3 x signed D_BITS  ray direction, first-word-fall-through.
REQ-011 tri_addr  out  M_BITS  triangle memory address.
REQ-012 tri_rd_en  out  1  triangle memory read strobe.
REQ-013 tri_v0, tri_v1, tri_v2  in  3 x signed D_BITS each  vertices; valid one cycle after tri_rd_en.
REQ-014 out_full  in  1  downstream intersect FIFO full.
REQ-015 out_wr_en  out  1  downstream write strobe.
REQ-016 out_origin, out_dir, out_v0, out_v1, out_v2  out  3 x signed D_BITS each  ray/triangle pair.
REQ-017 out_triangle_ID  out  M_BITS  index of triangle in the pair.
REQ-018 busy  out  1  high from ray acceptance until its last pair is written.

Function
REQ-019 FSM states: IDLE, RAY_RD, TRI_REQ, TRI_WAIT, EMIT.
REQ-020 IDLE: if !ray_empty, assert ray_rd_en, go to RAY_RD; else stay, all strobes low.
REQ-021 RAY_RD: ray_rd_en high exactly this one cycle; latch ray_origin, ray_dir, num_tri; clear index to 0; set busy; go to TRI_REQ, or to IDLE with busy cleared if sampled num_tri == 0.
REQ-022 TRI_REQ: drive tri_addr = index, assert tri_rd_en for one cycle, go to TRI_WAIT.
REQ-023 TRI_WAIT: latch tri_v0..v2; go to EMIT.
REQ-024 EMIT: if !out_full, assert out_wr_en for one cycle with all out_* fields valid that cycle; out_triangle_ID = index; then if index == latched num_tri-1, clear busy and go to IDLE, else increment index and go to TRI_REQ.
REQ-025 EMIT with out_full high: hold state, out_wr_en low, no field changes, until out_full deasserts.
REQ-026 out_wr_en never asserted while out_full is high in the same cycle.
REQ-027 out_* fields hold their last written values between writes.
REQ-028 Per ray, exactly num_tri pairs emitted, IDs strictly 0,1,...,num_tri-1 in order; ID 0 marks start of a new ray downstream.
REQ-029 Index never wraps; num_tri up to 2^M_BITS-1 supported; terminal compare uses the latched count, so num_tri changes mid-ray are ignored.
REQ-030 Steady-state throughput: one pair per 3 cycles without backpressure.
REQ-031 ray_rd_en and tri_rd_en never asserted simultaneously.
REQ-032 No arithmetic on coordinates; values pass through bit-exact.

Reset
REQ-033 On reset: state IDLE, index 0, busy 0, ray_rd_en 0, tri_rd_en 0, out_wr_en 0, tri_addr 0, out_triangle_ID 0, all coordinate outputs 0.
REQ-034 Reset asserted mid-ray abandons the ray immediately; no further pairs for it; the next ray after reset starts at ID 0.

Structure
REQ-035 Shared package rt_pkg holds D_BITS, Q_BITS, M_BITS defaults and the vec3 typedef (3 x signed D_BITS), used by this block and the accumulate stage.
REQ-036 Single flat module; no sub-module; triangle memory is external.

Verification
REQ-037 Reset, ray_empty=1 for 20 cycles -> all strobes low, busy 0, outputs 0.
REQ-038 One ray origin (1,2,3) dir (0,0,-1), num_tri=4, memory tri k vertices = k*16 -> 4 writes, IDs 0,1,2,3, correct vertices, origin/dir unchanged, writes 3 cycles apart, busy drops after ID 3.
REQ-039 num_tri=3, out_full held high 10 cycles while in EMIT for ID 1 -> no write during stall, ID 1 written once after release, no duplicate or skipped IDs.
REQ-040 num_tri=0 with two rays queued -> both rays read (two ray_rd_en pulses), zero writes.
REQ-041 Two back-to-back rays, num_tri=2 -> ID sequence 0,1,0,1 with second ray's origin on writes 3-4; num_tri changed to 5 mid-first-ray has no effect on first ray.
REQ-042 Reset asserted after ID 2 of num_tri=6 -> no further writes for that ray; next ray emits from ID 0.
